// File: rtl/aes_in_packer_pkg.sv
// Shared types and constants for the AES input packer and its packet FIFO.
package aes_in_packer_pkg;

    localparam int AES_WORDS_PER_BLK = 4;
    localparam int AES_WORD_W        = 32;
    localparam int AES_BLK_W         = AES_WORDS_PER_BLK * AES_WORD_W;
    localparam int AES_PART_W        = AES_BLK_W - AES_WORD_W;

    // One complete block as handed to the AES controller.
    typedef struct packed {
        logic [AES_BLK_W-1:0] data;
        logic                 en_de;
        logic                 set_key;
        logic                 valid;
    } in_packet_t;

    // Word assembler states.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } asm_state_t;

    // Place a host word into the partial register at lane (3 - beat).
    // Beat 3 never lands here: it is taken straight from the input bus.
    function automatic logic [AES_PART_W-1:0] put_lane(
        input logic [AES_PART_W-1:0] part,
        input logic [1:0]            beat,
        input logic [AES_WORD_W-1:0] word
    );
        logic [AES_PART_W-1:0] res;
        res = part;
        case (beat)
            2'd0:    res[95:64] = word;
            2'd1:    res[63:32] = word;
            2'd2:    res[31:0]  = word;
            default: res        = part;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/aes_pkt_fifo.sv
// Packet FIFO with a registered head: o_head is updated on the edge that
// pushes into an empty queue or pops, so the consumer sees no RAM read path.
module aes_pkt_fifo
    import aes_in_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  in_packet_t               i_push_data,
    input  logic                     i_pop,
    output in_packet_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_room
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    in_packet_t       r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    in_packet_t       r_head;
    logic             r_room;

    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rd_next;
    logic [CW-1:0]    w_count_next;
    in_packet_t       w_head_next;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_head  = r_head;
    assign o_room  = r_room;

    // Guarded push/pop, next pointers, and the packet that becomes the head.
    always_comb begin
        w_push       = i_push && !o_full;
        w_pop        = i_pop && !o_empty;
        w_rd_next    = w_pop ? (r_rd + PW'(1)) : r_rd;
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        // The slot being written this cycle is not in r_mem yet, so forward it.
        if (w_push && (r_wr == w_rd_next)) begin
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Packet storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    // Pointers, occupancy, registered head and next-cycle room flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= {PW{1'b0}};
            r_rd    <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_head  <= '0;
            r_room  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            r_room  <= (w_count_next != CW'(DEPTH));
            if (w_count_next != {CW{1'b0}}) begin
                r_head <= w_head_next;
            end else begin
                // Empty: data bits keep their last value, only valid drops.
                r_head.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_in_packer.sv
// Collects four 32-bit host words into one 128-bit packet and queues it for
// the AES controller; flags framing errors on the host stream.
module aes_in_packer
    import aes_in_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [AES_WORD_W-1:0]    s_data,
    input  logic                     s_first,
    input  logic                     s_en_de,
    input  logic                     s_set_key,
    output in_packet_t               pkt_out,
    input  logic                     pkt_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_frame
);

    localparam logic [1:0] LAST_BEAT = 2'(AES_WORDS_PER_BLK - 1);

    asm_state_t              r_state;
    logic [1:0]              r_beat;
    logic [AES_PART_W-1:0]   r_part;
    logic                    r_en_de;
    logic                    r_set_key;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_room;
    in_packet_t              w_pkt;

    assign s_ready   = w_room;
    assign err_frame = r_err;

    // Handshakes and the completed packet presented to the FIFO on the last beat.
    always_comb begin
        w_accept      = s_valid && w_room;
        w_pop         = pkt_ready && !w_empty;
        w_push        = w_accept && (r_state == ST_COLLECT) && !s_first
                        && (r_beat == LAST_BEAT) && !w_full;
        w_pkt         = '0;
        w_pkt.data    = {r_part, s_data};
        w_pkt.en_de   = r_en_de;
        w_pkt.set_key = r_set_key;
        w_pkt.valid   = 1'b1;
    end

    // Assembler FSM: beat counter, partial block and framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= 2'd0;
            r_part    <= {AES_PART_W{1'b0}};
            r_en_de   <= 1'b0;
            r_set_key <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (s_first) begin
                            r_part    <= put_lane(r_part, 2'd0, s_data);
                            r_en_de   <= s_en_de;
                            r_set_key <= s_set_key;
                            r_beat    <= 2'd1;
                            r_state   <= ST_COLLECT;
                        end else begin
                            // Orphan word: dropped.
                            r_err <= 1'b1;
                        end
                    end
                    ST_COLLECT: begin
                        if (s_first) begin
                            // Premature start: abandon the partial block, restart on this word.
                            r_err     <= 1'b1;
                            r_part    <= put_lane(r_part, 2'd0, s_data);
                            r_en_de   <= s_en_de;
                            r_set_key <= s_set_key;
                            r_beat    <= 2'd1;
                        end else if (r_beat == LAST_BEAT) begin
                            r_beat  <= 2'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_part <= put_lane(r_part, r_beat, s_data);
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_beat  <= 2'd0;
                    end
                endcase
            end
        end
    end

    aes_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_pkt),
        .i_pop       (w_pop),
        .o_head      (pkt_out),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_room      (w_room)
    );

endmodule

// File: tb/tb_aes_in_packer.sv
// Directed self-checking bench for aes_in_packer (DEPTH = 4).
module tb_aes_in_packer;
    import aes_in_packer_pkg::*;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_first;
    logic         s_en_de;
    logic         s_set_key;
    in_packet_t   pkt_out;
    logic         pkt_ready;
    logic [2:0]   fifo_count;
    logic         err_frame;

    int n_checks = 0;
    int n_fails  = 0;

    logic [127:0] blk [4];

    aes_in_packer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_first    (s_first),
        .s_en_de    (s_en_de),
        .s_set_key  (s_set_key),
        .pkt_out    (pkt_out),
        .pkt_ready  (pkt_ready),
        .fifo_count (fifo_count),
        .err_frame  (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [130:0] mk(input logic [127:0] d, input logic e, input logic k);
        return {d, e, k, 1'b1};
    endfunction

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic put(input logic [31:0] w, input logic f, input logic e, input logic k);
        int n;
        s_valid = 1'b1; s_data = w; s_first = f; s_en_de = e; s_set_key = k;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("put_timeout", 160'd0, 160'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_first = 1'b0;
    endtask

    task automatic put_block(input logic [127:0] d, input logic e, input logic k);
        put(d[127:96], 1'b1, e, k);
        put(d[95:64],  1'b0, e, k);
        put(d[63:32],  1'b0, e, k);
        put(d[31:0],   1'b0, e, k);
    endtask

    task automatic pop_one();
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_first = 1'b0;
        s_en_de = 1'b0; s_set_key = 1'b0; pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 160'(s_ready), 160'd0);
        check("rst_count",   160'(fifo_count), 160'd0);
        check("rst_pkt_out", 160'(pkt_out), 160'd0);
        check("rst_err",     160'(err_frame), 160'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_s_ready", 160'(s_ready), 160'd1);

        // 1: single key block
        put_block(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1);
        check("t1_pkt", 160'(pkt_out), 160'(mk(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1)));
        check("t1_count", 160'(fifo_count), 160'd1);
        pop_one();
        check("t1_pop_count", 160'(fifo_count), 160'd0);
        check("t1_pop_valid", 160'(pkt_out.valid), 160'd0);
        check("t1_hold_data", 160'(pkt_out.data), 160'(128'h000102030405060708090a0b0c0d0e0f));

        // 2: fill to DEPTH with mixed key/data blocks
        blk[0] = 128'hA0000000_A0000001_A0000002_A0000003;
        blk[1] = 128'hB0000000_B0000001_B0000002_B0000003;
        blk[2] = 128'hC0000000_C0000001_C0000002_C0000003;
        blk[3] = 128'hD0000000_D0000001_D0000002_D0000003;
        put_block(blk[0], 1'b1, 1'b0);
        put_block(blk[1], 1'b0, 1'b0);
        put_block(blk[2], 1'b0, 1'b1);
        put_block(blk[3], 1'b1, 1'b0);
        check("t2_full_count", 160'(fifo_count), 160'd4);
        check("t2_full_ready", 160'(s_ready), 160'd0);
        s_valid = 1'b1; s_data = 32'h55555555; s_first = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t2_blocked_count", 160'(fifo_count), 160'd4);
        check("t2_blocked_err",   160'(err_frame), 160'd0);
        check("t2_head0", 160'(pkt_out), 160'(mk(blk[0], 1'b1, 1'b0)));
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0; s_valid = 1'b0;
        check("t2_pop_count", 160'(fifo_count), 160'd3);
        check("t2_pop_ready", 160'(s_ready), 160'd1);
        check("t2_pop_err",   160'(err_frame), 160'd0);
        check("t2_head1", 160'(pkt_out), 160'(mk(blk[1], 1'b0, 1'b0)));
        pop_one();
        check("t2_head2", 160'(pkt_out), 160'(mk(blk[2], 1'b0, 1'b1)));
        pop_one();
        check("t2_head3", 160'(pkt_out), 160'(mk(blk[3], 1'b1, 1'b0)));
        pop_one();
        check("t2_empty", 160'(fifo_count), 160'd0);

        // 3: push and pop in the same cycle at count = 1
        put_block(128'h11111111_22222222_33333333_44444444, 1'b0, 1'b0);
        put(32'h99990000, 1'b1, 1'b1, 1'b0);
        put(32'h99990001, 1'b0, 1'b1, 1'b0);
        put(32'h99990002, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b1; s_data = 32'h99990003; s_first = 1'b0; pkt_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; pkt_ready = 1'b0;
        check("t3_count", 160'(fifo_count), 160'd1);
        check("t3_pkt", 160'(pkt_out), 160'(mk(128'h99990000_99990001_99990002_99990003, 1'b1, 1'b0)));
        pop_one();

        // 4: s_first re-asserted at beat 2
        put(32'h77770000, 1'b1, 1'b0, 1'b1);
        put(32'h77770001, 1'b0, 1'b0, 1'b1);
        put(32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        check("t4_err_pulse", 160'(err_frame), 160'd1);
        check("t4_count_mid", 160'(fifo_count), 160'd0);
        put(32'hCAFE1234, 1'b0, 1'b0, 1'b1);
        check("t4_err_clear", 160'(err_frame), 160'd0);
        put(32'h5678ABCD, 1'b0, 1'b0, 1'b1);
        put(32'h01234567, 1'b0, 1'b0, 1'b1);
        check("t4_pkt", 160'(pkt_out), 160'(mk(128'hDEADBEEF_CAFE1234_5678ABCD_01234567, 1'b1, 1'b0)));
        check("t4_count", 160'(fifo_count), 160'd1);

        // 5: orphan word in IDLE (one packet queued)
        put(32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        check("t5_err_pulse", 160'(err_frame), 160'd1);
        check("t5_count", 160'(fifo_count), 160'd1);
        @(posedge clk); #1;
        check("t5_err_clear", 160'(err_frame), 160'd0);

        // 6: reset at beat 2 with two packets queued
        put_block(128'hEEEE0000_EEEE0001_EEEE0002_EEEE0003, 1'b0, 1'b0);
        check("t6_pre_count", 160'(fifo_count), 160'd2);
        put(32'h66660000, 1'b1, 1'b0, 1'b0);
        put(32'h66660001, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_count", 160'(fifo_count), 160'd0);
        check("t6_rst_valid", 160'(pkt_out.valid), 160'd0);
        check("t6_rst_err",   160'(err_frame), 160'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        put(32'h12340000, 1'b1, 1'b1, 1'b1);
        check("t6_no_err", 160'(err_frame), 160'd0);
        put(32'h12340001, 1'b0, 1'b1, 1'b1);
        put(32'h12340002, 1'b0, 1'b1, 1'b1);
        put(32'h12340003, 1'b0, 1'b1, 1'b1);
        check("t6_pkt", 160'(pkt_out), 160'(mk(128'h12340000_12340001_12340002_12340003, 1'b1, 1'b1)));
        check("t6_count", 160'(fifo_count), 160'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
